// File: rtl/demux14_pkg.sv
// Shared types and constants for the demux14 TDM receive path.
package demux14_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    HUNT,
    RECV
  } state_t;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 2'd3;

endpackage

// File: rtl/demux14_slot_ctr.sv
// Framing FSM and slot counter for the demux14 receiver.
// Emits store/complete strobes for the datapath and a registered sync_err pulse.
module demux14_slot_ctr
  import demux14_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic [SLOT_W-1:0] slot,
  output logic              store_en,
  output logic              frame_done,
  output logic              sync_err
);

  state_t state;

  // Strobes are combinational so the datapath captures on the same edge as the FSM advances.
  always_comb begin
    store_en   = in_valid && (in_sof || (state == RECV));
    frame_done = in_valid && !in_sof && (state == RECV) && (slot == LAST_SLOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          sync_err <= (state == RECV);
          slot     <= SLOT_W'(1);
          state    <= RECV;
        end else if (state == RECV) begin
          if (slot == LAST_SLOT) begin
            slot  <= '0;
            state <= HUNT;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/demux14_tdm_rx.sv
// Receive end of the 4:1 TDM link: shadow-buffers one frame and presents a..d together.
// Optional DEMUX14_ERRCNT_EN adds a saturating 8-bit sync-error counter output err_cnt.
module demux14_tdm_rx
  import demux14_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  c,
  output logic [WIDTH-1:0]  d,
  output logic              out_valid,
  output logic [SLOT_W-1:0] slot,
`ifdef DEMUX14_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              sync_err
);

  logic              store_en;
  logic              frame_done;
  logic [SLOT_W-1:0] wr_idx;
  logic [WIDTH-1:0]  shadow0, shadow1, shadow2;

  demux14_slot_ctr u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .slot       (slot),
    .store_en   (store_en),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  // An SOF always lands in slot 0, whatever slot the counter currently expects.
  always_comb wr_idx = in_sof ? '0 : slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow0   <= '0;
      shadow1   <= '0;
      shadow2   <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= frame_done;
      if (frame_done) begin
        a <= shadow0;
        b <= shadow1;
        c <= shadow2;
        d <= in_data;
      end else if (store_en) begin
        case (wr_idx)
          2'd0:    shadow0 <= in_data;
          2'd1:    shadow1 <= in_data;
          2'd2:    shadow2 <= in_data;
          default: ;
        endcase
      end
    end
  end

`ifdef DEMUX14_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (sync_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux14_tdm_rx.sv
// Directed, table-driven bench for demux14_tdm_rx (err_cnt checks when DEMUX14_ERRCNT_EN is set).
module tb_demux14_tdm_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic [7:0] a, b, c, d;
  logic       out_valid;
  logic [1:0] slot;
  logic       sync_err;
`ifdef DEMUX14_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  demux14_tdm_rx #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .slot      (slot),
`ifdef DEMUX14_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  din;
    logic [31:0] eabcd;
    logic        eov;
    logic [1:0]  eslot;
    logic        ese;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic s, input logic [7:0] din,
                              input logic [31:0] eabcd, input logic eov,
                              input logic [1:0] eslot, input logic ese);
    vec_t t;
    t.v = v; t.s = s; t.din = din; t.eabcd = eabcd;
    t.eov = eov; t.eslot = eslot; t.ese = ese;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] din);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_data  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] eabcd, input logic eov,
                           input logic [1:0] eslot, input logic ese);
    check({tag, ".abcd"}, {a, b, c, d}, eabcd);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
    check({tag, ".slot"}, {30'd0, slot}, {30'd0, eslot});
    check({tag, ".sync_err"}, {31'd0, sync_err}, {31'd0, ese});
  endtask

  initial begin
    // clean frame
    add(1, 1, 8'h11, 32'h00000000, 0, 2'd1, 0);
    add(1, 0, 8'h22, 32'h00000000, 0, 2'd2, 0);
    add(1, 0, 8'h33, 32'h00000000, 0, 2'd3, 0);
    add(1, 0, 8'h44, 32'h11223344, 1, 2'd0, 0);
    add(0, 0, 8'hEE, 32'h11223344, 0, 2'd0, 0);
    // frame with three idle cycles between samples
    add(1, 1, 8'h55, 32'h11223344, 0, 2'd1, 0);
    add(0, 0, 8'hEE, 32'h11223344, 0, 2'd1, 0);
    add(0, 1, 8'hEE, 32'h11223344, 0, 2'd1, 0);
    add(0, 0, 8'hEE, 32'h11223344, 0, 2'd1, 0);
    add(1, 0, 8'h66, 32'h11223344, 0, 2'd2, 0);
    add(0, 0, 8'hEE, 32'h11223344, 0, 2'd2, 0);
    add(0, 0, 8'hEE, 32'h11223344, 0, 2'd2, 0);
    add(0, 0, 8'hEE, 32'h11223344, 0, 2'd2, 0);
    add(1, 0, 8'h77, 32'h11223344, 0, 2'd3, 0);
    add(0, 0, 8'hEE, 32'h11223344, 0, 2'd3, 0);
    add(0, 1, 8'hEE, 32'h11223344, 0, 2'd3, 0);
    add(0, 0, 8'hEE, 32'h11223344, 0, 2'd3, 0);
    add(1, 0, 8'h88, 32'h55667788, 1, 2'd0, 0);
    // back-to-back frames, no bubbles
    add(1, 1, 8'hA0, 32'h55667788, 0, 2'd1, 0);
    add(1, 0, 8'hA1, 32'h55667788, 0, 2'd2, 0);
    add(1, 0, 8'hA2, 32'h55667788, 0, 2'd3, 0);
    add(1, 0, 8'hA3, 32'hA0A1A2A3, 1, 2'd0, 0);
    add(1, 1, 8'hB0, 32'hA0A1A2A3, 0, 2'd1, 0);
    add(1, 0, 8'hB1, 32'hA0A1A2A3, 0, 2'd2, 0);
    add(1, 0, 8'hB2, 32'hA0A1A2A3, 0, 2'd3, 0);
    add(1, 0, 8'hB3, 32'hB0B1B2B3, 1, 2'd0, 0);
    // premature SOF on the third sample
    add(1, 1, 8'h01, 32'hB0B1B2B3, 0, 2'd1, 0);
    add(1, 0, 8'h02, 32'hB0B1B2B3, 0, 2'd2, 0);
    add(1, 1, 8'h05, 32'hB0B1B2B3, 0, 2'd1, 1);
    add(1, 0, 8'h06, 32'hB0B1B2B3, 0, 2'd2, 0);
    add(1, 0, 8'h07, 32'hB0B1B2B3, 0, 2'd3, 0);
    add(1, 0, 8'h08, 32'h05060708, 1, 2'd0, 0);
    // samples without SOF are dropped silently while hunting
    add(1, 0, 8'h99, 32'h05060708, 0, 2'd0, 0);
    add(1, 0, 8'h98, 32'h05060708, 0, 2'd0, 0);
    add(1, 1, 8'h12, 32'h05060708, 0, 2'd1, 0);
    add(1, 0, 8'h34, 32'h05060708, 0, 2'd2, 0);
    add(1, 0, 8'h56, 32'h05060708, 0, 2'd3, 0);
    add(1, 0, 8'h78, 32'h12345678, 1, 2'd0, 0);
    // SOF without valid is ignored in both states
    add(0, 1, 8'hFF, 32'h12345678, 0, 2'd0, 0);
    add(1, 1, 8'h01, 32'h12345678, 0, 2'd1, 0);
    add(0, 1, 8'hFF, 32'h12345678, 0, 2'd1, 0);

    // reset held with traffic present
    rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b1; in_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 1'b0, 2'd0, 1'b0);
`ifdef DEMUX14_ERRCNT_EN
    check("reset.err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i].eabcd, vecs[i].eov, vecs[i].eslot, vecs[i].ese);
    end

    // asynchronous reset mid-frame: outputs clear before any clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // the partial frame is gone; a continuation sample is dropped in HUNT
    step(1, 0, 8'hC2);
    check_all("post_rst_drop", 32'h0, 1'b0, 2'd0, 1'b0);
    step(1, 1, 8'hD0);
    step(1, 0, 8'hD1);
    step(1, 0, 8'hD2);
    step(1, 0, 8'hD3);
    check_all("post_rst_frame", 32'hD0D1D2D3, 1'b1, 2'd0, 1'b0);

`ifdef DEMUX14_ERRCNT_EN
    step(1, 1, 8'h00);
    for (int i = 0; i < 300; i++) step(1, 1, 8'(i));
    step(0, 0, 8'h00);
    check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    check("err_cnt_outputs", {a, b, c, d}, 32'hD0D1D2D3);
`endif

    step(0, 0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit 200000 expected earlier finish");
    $fatal(1);
  end

endmodule
